program_loader: RTL and testbench

Instruction-memory loader that sits between a byte-stream source (UART receiver or switch/debounce front end) and the instruction BRAM port that the CPU control path reads in its fetch steps. While the CPU is held in reset, it assembles a framed little-endian byte stream into 32-bit words and writes them sequentially from address 0. It verifies an XOR checksum and releases the CPU on success. It is the writer for the instruction memory that the control path only reads.

---
 rtl/program_loader.sv | 218 +++++++++++++++++++++
 tb/tb_program_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// ============================================================================
//  Module   : program_loader
//  Purpose  : Framed byte-stream loader for the instruction BRAM. Assembles
//             little-endian 32-bit words, writes them from address 0, checks
//             an XOR checksum and releases the CPU hold on success.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_all_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Word index needs one extra bit so a full-depth load ends at 2^ADDR_W
    localparam int          IDX_W     = ADDR_W + 1;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR0    = 3'd1,
        S_HDR1    = 3'd2,
        S_PAYLOAD = 3'd3,
        S_WRITE   = 3'd4,
        S_CHK     = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [15:0]         n_q, n_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          lane_q, lane_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          xor_q, xor_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                imem_en_q, imem_en_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                byte_ready_q, byte_ready_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic [31:0]         n_hdr_wide;
    logic [31:0]         idx_next_wide;

    // Next-state and next-output computation for the whole loader
    always_comb begin
        state_d      = state_q;
        cnt_lo_d     = cnt_lo_q;
        n_d          = n_q;
        idx_d        = idx_q;
        lane_d       = lane_q;
        asm_d        = asm_q;
        xor_d        = xor_q;
        done_d       = done_q;
        error_d      = error_q;
        cpu_hold_d   = cpu_hold_q;
        imem_en_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        // byte_ready_q is a pure decode of the registered state
        accept        = byte_valid && byte_ready_q;
        n_hdr_wide    = {16'd0, byte_data, cnt_lo_q};
        idx_next_wide = 32'(idx_q) + 32'd1;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    idx_d      = '0;
                    lane_d     = 2'd0;
                    xor_d      = 8'd0;
                    cpu_hold_d = 1'b1;
                    state_d    = S_HDR0;
                end
            end
            S_HDR0: begin
                if (accept) begin
                    cnt_lo_d = byte_data;
                    xor_d    = xor_q ^ byte_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    n_d   = {byte_data, cnt_lo_q};
                    xor_d = xor_q ^ byte_data;
                    if (n_hdr_wide > MAX_WORDS) begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end else if (n_hdr_wide == 32'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    xor_d = xor_q ^ byte_data;
                    case (lane_q)
                        2'd0: asm_d[7:0]   = byte_data;
                        2'd1: asm_d[15:8]  = byte_data;
                        2'd2: asm_d[23:16] = byte_data;
                        default: ;
                    endcase
                    if (lane_q == 2'd3) begin
                        // Registered write strobe lands during the WRITE cycle
                        imem_en_d    = 1'b1;
                        imem_addr_d  = idx_q[ADDR_W-1:0];
                        imem_wdata_d = {byte_data, asm_q};
                        lane_d       = 2'd0;
                        state_d      = S_WRITE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_next_wide == {16'd0, n_q}) begin
                    state_d = S_CHK;
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_CHK: begin
                if (accept) begin
                    if (byte_data == xor_q) begin
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                       (state_d == S_PAYLOAD) || (state_d == S_CHK);
        busy_d       = (state_d == S_HDR0) || (state_d == S_HDR1) ||
                       (state_d == S_PAYLOAD) || (state_d == S_WRITE) ||
                       (state_d == S_CHK);
    end

    // State and output registers; reset leaves the CPU held
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            state_q      <= S_IDLE;
            cnt_lo_q     <= 8'd0;
            n_q          <= 16'd0;
            idx_q        <= '0;
            lane_q       <= 2'd0;
            asm_q        <= 24'd0;
            xor_q        <= 8'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            imem_en_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_lo_q     <= cnt_lo_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            xor_q        <= xor_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_hold_q   <= cpu_hold_d;
            imem_en_q    <= imem_en_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_en    = imem_en_q;
    assign imem_we    = imem_en_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader (table vectors, random
//             frames against a frame-level reference model, corner sequences).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int MAXC   = 600;

    logic              clk = 1'b0;
    logic              reset_all_n;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_en;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset_all_n (reset_all_n),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_en     (imem_en),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Observed BRAM writes, stamped with the cycle they occurred in
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    wr_t        wq[$];
    int         cyc_cnt = 0;
    logic [7:0] frame_q[$];

    always @(posedge clk) cyc_cnt++;

    // Capture every write and confirm no byte can be taken in that cycle
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wq.push_back('{imem_addr, imem_wdata, cyc_cnt});
            check("byte_ready_in_write", {31'd0, byte_ready}, 32'd0);
            check("imem_en_with_we", {31'd0, imem_en}, 32'd1);
        end
    end

    // Called at a negedge; start is seen by the next rising edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer frame_q bytes with probability pv percent per cycle; returns at
    // the negedge following the last accepting edge (or when load ends)
    task automatic feed(input int pv, output bit timed_out);
        int i   = 0;
        int cyc = 0;
        timed_out = 1'b0;
        while (i < frame_q.size() && busy === 1'b1 && cyc < MAXC) begin
            byte_valid = ($urandom_range(0, 99) < pv);
            byte_data  = byte_valid ? frame_q[i] : 8'($urandom);
            if (byte_valid && byte_ready) i++;
            @(negedge clk);
            cyc++;
        end
        byte_valid = 1'b0;
        if (cyc >= MAXC) timed_out = 1'b1;
    endtask

    // Build a frame of n words with a correct or corrupted checksum
    task automatic gen_frame(input int n, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        x = frame_q[0] ^ frame_q[1];
        if (n > DEPTH) begin
            for (int k = 0; k < 4; k++) frame_q.push_back(8'($urandom));
        end else begin
            for (int k = 0; k < 4 * n; k++) begin
                b = 8'($urandom);
                x ^= b;
                frame_q.push_back(b);
            end
            frame_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        end
    endtask

    // Reference model: decode frame_q from the frame rules, then run the DUT
    task automatic load_and_check(input int pv, input string tag);
        int          n;
        logic [7:0]  x;
        logic [31:0] word;
        logic [31:0] exp_w[$];
        bit          exp_done;
        bit          to;
        n = int'({frame_q[1], frame_q[0]});
        x = frame_q[0] ^ frame_q[1];
        exp_done = 1'b0;
        if (n <= DEPTH) begin
            for (int w = 0; w < n; w++) begin
                word = 32'd0;
                for (int b = 0; b < 4; b++) begin
                    word |= 32'(frame_q[2 + 4 * w + b]) << (8 * b);
                    x ^= frame_q[2 + 4 * w + b];
                end
                exp_w.push_back(word);
            end
            exp_done = (frame_q[2 + 4 * n] == x);
        end
        wq.delete();
        pulse_start();
        feed(pv, to);
        check({tag, "_timeout"}, {31'd0, to}, 32'd0);
        check({tag, "_nwrites"}, wq.size(), exp_w.size());
        foreach (exp_w[k]) begin
            if (k < wq.size()) begin
                check({tag, "_addr"}, 32'(wq[k].addr), 32'(k));
                check({tag, "_data"}, wq[k].data, exp_w[k]);
            end
        end
        check({tag, "_done"},     {31'd0, done},     {31'd0, exp_done});
        check({tag, "_error"},    {31'd0, error},    {31'd0, !exp_done});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, !exp_done});
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_ready"},    {31'd0, byte_ready}, 32'd0);
    endtask

    typedef struct {
        logic [63:0] bytes;   // byte i in bits 8i+7:8i
        int          len;
        int          pv;
        int          nw;
        logic [31:0] w0;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit to;

        tbl[0] = '{64'h00888C0100040001, 7, 100, 1, 32'h8C010004, 1'b1, 1'b0};
        tbl[1] = '{64'h00898C0100040001, 7, 100, 1, 32'h8C010004, 1'b0, 1'b1};
        tbl[2] = '{64'h0000000000000000, 3, 100, 0, 32'h0,        1'b1, 1'b0};
        tbl[3] = '{64'h0000000000000005, 2, 100, 0, 32'h0,        1'b0, 1'b1};
        tbl[4] = '{64'h00000000007E0000, 3,  60, 0, 32'h0,        1'b0, 1'b1};
        tbl[5] = '{64'h0001FFFFFFFF0001, 7,  50, 1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[6] = '{64'h0009123456780001, 7,  40, 1, 32'h12345678, 1'b1, 1'b0};

        reset_all_n = 1'b0;
        start       = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_error",      {31'd0, error},      32'd0);
        check("rst_imem_en",    {31'd0, imem_en},    32'd0);
        check("rst_imem_we",    {31'd0, imem_we},    32'd0);
        check("rst_imem_addr",  32'(imem_addr),      32'd0);
        check("rst_imem_wdata", imem_wdata,          32'd0);
        reset_all_n = 1'b1;
        @(negedge clk);
        check("idle_no_ready", {31'd0, byte_ready}, 32'd0);

        // Table-driven frames
        for (int t = 0; t < 7; t++) begin
            logic [63:0] bv;
            bv = tbl[t].bytes;
            frame_q.delete();
            for (int k = 0; k < tbl[t].len; k++) frame_q.push_back(bv[8 * k +: 8]);
            wq.delete();
            pulse_start();
            check("tbl_busy_after_start", {31'd0, busy}, 32'd1);
            feed(tbl[t].pv, to);
            check("tbl_timeout", {31'd0, to}, 32'd0);
            check("tbl_nwrites", wq.size(), tbl[t].nw);
            if (tbl[t].nw > 0 && wq.size() > 0) begin
                check("tbl_addr0", 32'(wq[0].addr), 32'd0);
                check("tbl_data0", wq[0].data, tbl[t].w0);
            end
            check("tbl_done",     {31'd0, done},     {31'd0, tbl[t].exp_done});
            check("tbl_error",    {31'd0, error},    {31'd0, tbl[t].exp_err});
            check("tbl_cpu_hold", {31'd0, cpu_hold}, {31'd0, !tbl[t].exp_done});
            check("tbl_ready",    {31'd0, byte_ready}, 32'd0);
        end

        // Overflow: ERR refuses bytes, then a new start clears error
        frame_q.delete();
        frame_q.push_back(8'h05);
        frame_q.push_back(8'h00);
        wq.delete();
        pulse_start();
        feed(100, to);
        check("ovf_error", {31'd0, error}, 32'd1);
        byte_valid = 1'b1;
        byte_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("ovf_ready_stays_low", {31'd0, byte_ready}, 32'd0);
        check("ovf_no_writes", wq.size(), 32'd0);
        byte_valid = 1'b0;
        pulse_start();
        check("ovf_restart_error_clr", {31'd0, error},      32'd0);
        check("ovf_restart_busy",      {31'd0, busy},       32'd1);
        check("ovf_restart_ready",     {31'd0, byte_ready}, 32'd1);
        frame_q.delete();
        repeat (3) frame_q.push_back(8'h00);
        feed(100, to);
        check("ovf_then_empty_done", {31'd0, done}, 32'd1);

        // Throughput: 3 words at full rate are written every 5 cycles
        gen_frame(3, 1'b1);
        load_and_check(100, "thru");
        if (wq.size() >= 3) begin
            check("thru_gap01", wq[1].cyc - wq[0].cyc, 32'd5);
            check("thru_gap12", wq[2].cyc - wq[1].cyc, 32'd5);
        end

        // Back-pressure 3-word frame and random frames, including full depth
        gen_frame(3, 1'b1);
        load_and_check(35, "bp3");
        for (int it = 0; it < 14; it++) begin
            int n;
            if (it == 0)          n = DEPTH;
            else if (it % 5 == 4) n = DEPTH + 1 + int'($urandom_range(0, 2));
            else                  n = int'($urandom_range(0, DEPTH));
            gen_frame(n, ($urandom_range(0, 3) != 0));
            load_and_check(int'($urandom_range(25, 100)), "rnd");
        end

        // Reset after 6 payload bytes of a 2-word frame
        gen_frame(2, 1'b1);
        frame_q = frame_q[0:7];
        wq.delete();
        pulse_start();
        feed(100, to);
        check("mid_first_write", wq.size(), 32'd1);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        reset_all_n = 1'b0;
        #1;
        check("mid_rst_cpu_hold", {31'd0, cpu_hold},   32'd1);
        check("mid_rst_busy",     {31'd0, busy},       32'd0);
        check("mid_rst_ready",    {31'd0, byte_ready}, 32'd0);
        @(negedge clk);
        reset_all_n = 1'b1;
        @(negedge clk);
        gen_frame(2, 1'b1);
        load_and_check(100, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
